// File: rtl/arp_cache_if.sv
// Bundle of lookup, learning, ageing and ARP-transmit signals between
// the user/UDP side (master) and the ARP cache (slave).
interface arp_cache_if;
  logic        upd_valid;
  logic [31:0] upd_ip;
  logic [47:0] upd_mac;
  logic        lkp_req;
  logic [31:0] lkp_ip;
  logic        lkp_done;
  logic        lkp_hit;
  logic [47:0] lkp_mac;
  logic        busy;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [31:0] des_ip;
  logic [47:0] des_mac;
  logic        arp_tx_done;
  logic        age_tick;

  modport slave (
    input  upd_valid, upd_ip, upd_mac, lkp_req, lkp_ip, arp_tx_done, age_tick,
    output lkp_done, lkp_hit, lkp_mac, busy, arp_tx_en, arp_tx_type, des_ip, des_mac
  );

  modport master (
    output upd_valid, upd_ip, upd_mac, lkp_req, lkp_ip, arp_tx_done, age_tick,
    input  lkp_done, lkp_hit, lkp_mac, busy, arp_tx_en, arp_tx_type, des_ip, des_mac
  );
endinterface

// File: rtl/arp_cache.sv
// IP->MAC resolution cache: learns bindings from received ARP frames, ages them
// out, and resolves lookups either from the table or by issuing ARP requests.
module arp_cache #(
  parameter int ENTRIES        = 4,
  parameter int TIMEOUT_CYCLES = 125000,
  parameter int MAX_TRY        = 3,
  parameter int AGE_MAX        = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  arp_cache_if.slave                     bus,
  output logic [$clog2(ENTRIES+1)-1:0]   entry_cnt
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES+1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = $clog2(MAX_TRY+1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEARCH   = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_WAIT_TX  = 3'd3;
  localparam logic [2:0] S_WAIT_RSP = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [47:0] mac;
    logic [7:0]  age;
  } entry_t;

  entry_t          tab [ENTRIES];
  logic [2:0]      state;
  logic [31:0]     lip;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   tries;
  logic            hit_r;
  logic [47:0]     mac_r;
  logic [31:0]     des_ip_q;
  logic [47:0]     des_mac_q;

  // Write slot for a learned binding: refresh existing, else first free, else oldest.
  logic            upd_hit, upd_free;
  logic [IW-1:0]   upd_hit_idx, free_idx, old_idx, wr_idx;
  logic [7:0]      old_age;
  always_comb begin
    upd_hit     = 1'b0;
    upd_hit_idx = '0;
    upd_free    = 1'b0;
    free_idx    = '0;
    old_idx     = '0;
    old_age     = tab[0].age;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (tab[i].valid && tab[i].ip == bus.upd_ip) begin
        upd_hit     = 1'b1;
        upd_hit_idx = IW'(i);
      end
      if (!tab[i].valid) begin
        upd_free = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int i = 1; i < ENTRIES; i++) begin
      if (tab[i].age > old_age) begin
        old_age = tab[i].age;
        old_idx = IW'(i);
      end
    end
    wr_idx = upd_hit ? upd_hit_idx : (upd_free ? free_idx : old_idx);
  end

  logic        tab_hit, rsp_match;
  logic [47:0] tab_mac;
  always_comb begin
    tab_hit = 1'b0;
    tab_mac = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (tab[i].valid && tab[i].ip == lip) begin
        tab_hit = 1'b1;
        tab_mac = tab[i].mac;
      end
    end
  end
  assign rsp_match = bus.upd_valid && (bus.upd_ip == lip);

  always_comb begin
    entry_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) entry_cnt = entry_cnt + CW'(tab[i].valid);
  end

  // A freshly written entry takes age 0 even when a tick lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) tab[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (bus.upd_valid && wr_idx == IW'(i)) begin
          tab[i] <= '{valid: 1'b1, ip: bus.upd_ip, mac: bus.upd_mac, age: 8'd0};
        end else if (bus.age_tick && tab[i].valid) begin
          tab[i].age <= tab[i].age + 8'd1;
          if (tab[i].age == 8'(AGE_MAX-1)) tab[i].valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      lip       <= '0;
      timer     <= '0;
      tries     <= '0;
      hit_r     <= 1'b0;
      mac_r     <= '0;
      des_ip_q  <= '0;
      des_mac_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.lkp_req) begin
          lip   <= bus.lkp_ip;
          state <= S_SEARCH;
        end
        S_SEARCH: begin
          if (rsp_match) begin
            hit_r <= 1'b1;
            mac_r <= bus.upd_mac;
            state <= S_DONE;
          end else if (tab_hit) begin
            hit_r <= 1'b1;
            mac_r <= tab_mac;
            state <= S_DONE;
          end else begin
            hit_r     <= 1'b0;
            mac_r     <= '0;
            tries     <= RW'(1);
            des_ip_q  <= lip;
            des_mac_q <= '1;
            state     <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (rsp_match) begin
            hit_r <= 1'b1;
            mac_r <= bus.upd_mac;
            state <= S_DONE;
          end else if (bus.arp_tx_done) begin
            timer <= '0;
            state <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_match) begin
            hit_r <= 1'b1;
            mac_r <= bus.upd_mac;
            state <= S_DONE;
          end else if (timer == TW'(TIMEOUT_CYCLES-1)) begin
            if (tries < RW'(MAX_TRY)) begin
              tries <= tries + RW'(1);
              state <= S_REQ;
            end else begin
              state <= S_DONE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.lkp_done    = (state == S_DONE);
  assign bus.lkp_hit     = (state == S_DONE) && hit_r;
  assign bus.lkp_mac     = ((state == S_DONE) && hit_r) ? mac_r : '0;
  assign bus.arp_tx_en   = (state == S_REQ);
  assign bus.arp_tx_type = 1'b0;
  assign bus.des_ip      = des_ip_q;
  assign bus.des_mac     = des_mac_q;
endmodule
